// File: rtl/sdram_port_arb.sv
// Burst-granular N-channel arbiter in front of sdram_ctl's single host port.
// A small tag FIFO remembers which channel issued each read burst so returned data can be steered back.
module sdram_port_arb #(
   parameter int N_CH      = 4,
   parameter int DW        = 16,
   parameter int BURST_LEN = 8,
   parameter int TAG_DEPTH = 4,
   parameter int PRIO_MODE = 0,
   localparam int IDW      = $clog2(N_CH)
) (
   input  logic               sdram_clk,
   input  logic               sdram_rst_,
   input  logic               sd_init_done,
   input  logic [N_CH-1:0]    ch_req,
   input  logic [N_CH-1:0]    ch_we,
   input  logic [N_CH*32-1:0] ch_addr,
   input  logic [N_CH*DW-1:0] ch_wdata,
   output logic [N_CH-1:0]    ch_valid,
   output logic [N_CH-1:0]    ch_rd_rdy,
   output logic [DW-1:0]      ch_rdata,
   output logic [IDW-1:0]     gnt_id,
   output logic               gnt_busy,
   output logic               err_orphan,
   output logic [31:0]        sys_addr,
   output logic               sys_rd,
   output logic               sys_wr,
   output logic [DW-1:0]      sys_wdata,
   input  logic [DW-1:0]      sys_rdata,
   input  logic               sys_rd_rdy,
   input  logic               sys_burst_rdy
);

   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam int TW = $clog2(TAG_DEPTH);

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  bcnt, rcnt;
   logic           rd_lock;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] tag_mem [TAG_DEPTH];
   logic [TW:0]    wr_ptr, rd_ptr;
   logic           tag_empty, tag_full;
   logic [N_CH-1:0] eligible;
   logic           win_found;
   logic [IDW-1:0] win_id;
   int             idx;
   logic           accept, push, pop, ret_beat, last_beat, burst_end, grant;

   assign tag_empty = (wr_ptr == rd_ptr);
   assign tag_full  = (wr_ptr == {~rd_ptr[TW], rd_ptr[TW-1:0]});
   assign eligible  = ch_req & (ch_we | {N_CH{~tag_full}});
   assign gnt_busy  = (state == BURST);
   assign ch_rdata  = sys_rdata;

   // Round-robin walks from the channel after the last winner; fixed priority walks from ch0.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 0; k < N_CH; k++) begin
         if (PRIO_MODE == 1) begin
            idx = k;
         end else begin
            idx = int'(rr_ptr) + 1 + k;
            if (idx >= N_CH) idx = idx - N_CH;
         end
         if (!win_found && eligible[idx]) begin
            win_found = 1'b1;
            win_id    = idx[IDW-1:0];
         end
      end
   end

   assign grant = (state == IDLE) && sd_init_done && win_found;

   always_comb begin
      sys_addr  = '0;
      sys_wdata = '0;
      sys_rd    = 1'b0;
      sys_wr    = 1'b0;
      ch_valid  = '0;
      accept    = 1'b0;
      if (state == BURST) begin
         sys_addr  = ch_addr[32*gnt_id +: 32];
         sys_wdata = ch_wdata[DW*gnt_id +: DW];
         sys_wr    = ch_req[gnt_id] & ch_we[gnt_id];
         sys_rd    = rd_lock | (ch_req[gnt_id] & ~ch_we[gnt_id]);
         accept    = (sys_rd | sys_wr) & sys_burst_rdy;
         ch_valid[gnt_id] = accept;
      end
   end

   // Once a read has started it is locked until the full burst is accepted; writes may stop early.
   assign push      = accept & sys_rd & ~rd_lock;
   assign last_beat = accept && (bcnt == CW'(BURST_LEN - 1));
   assign burst_end = last_beat | (~rd_lock & ~ch_req[gnt_id]);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = BURST;
         BURST:   if (burst_end) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_) begin
      if (!sdram_rst_) begin
         state   <= IDLE;
         gnt_id  <= '0;
         rr_ptr  <= IDW'(N_CH - 1);
         bcnt    <= '0;
         rd_lock <= 1'b0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            gnt_id <= win_id;
            rr_ptr <= win_id;
         end
         if (state == BURST) begin
            if (burst_end) begin
               bcnt    <= '0;
               rd_lock <= 1'b0;
            end else begin
               if (accept) bcnt <= bcnt + 1'b1;
               if (push) rd_lock <= 1'b1;
            end
         end
      end
   end

   // Return path: the FIFO head owns incoming read data until a full burst has come back.
   assign ret_beat = sys_rd_rdy & ~tag_empty;
   assign pop      = ret_beat && (rcnt == CW'(BURST_LEN - 1));

   always_comb begin
      ch_rd_rdy = '0;
      ch_rd_rdy[tag_mem[rd_ptr[TW-1:0]]] = ret_beat;
   end

   always_ff @(posedge sdram_clk) begin
      if (push) tag_mem[wr_ptr[TW-1:0]] <= gnt_id;
   end

   always_ff @(posedge sdram_clk or negedge sdram_rst_) begin
      if (!sdram_rst_) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rcnt       <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (ret_beat) rcnt <= pop ? '0 : rcnt + 1'b1;
         if (sys_rd_rdy && tag_empty) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a round-robin and a fixed-priority instance share random stimulus
// and are compared every cycle against a transaction-level model built on queues and counters.
module tb_sdram_port_arb;

   localparam int N_CH      = 4;
   localparam int DW        = 16;
   localparam int BURST_LEN = 8;
   localparam int TAG_DEPTH = 4;
   localparam int IDW       = 2;

   logic               sdram_clk = 1'b0;
   logic               sdram_rst_ = 1'b0;
   logic               sd_init_done = 1'b0;
   logic [N_CH-1:0]    ch_req = '0;
   logic [N_CH-1:0]    ch_we = '0;
   logic [N_CH*32-1:0] ch_addr = '0;
   logic [N_CH*DW-1:0] ch_wdata = '0;
   logic [DW-1:0]      sys_rdata = '0;
   logic               sys_rd_rdy = 1'b0;
   logic               sys_burst_rdy = 1'b0;

   logic [N_CH-1:0] ch_valid [2];
   logic [N_CH-1:0] ch_rd_rdy [2];
   logic [DW-1:0]   ch_rdata [2];
   logic [IDW-1:0]  gnt_id [2];
   logic            gnt_busy [2];
   logic            err_orphan [2];
   logic [31:0]     sys_addr [2];
   logic            sys_rd [2];
   logic            sys_wr [2];
   logic [DW-1:0]   sys_wdata [2];

   int check_cnt = 0;
   int pass_cnt  = 0;

   // Instance 0 is round-robin, instance 1 is fixed priority.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      sdram_port_arb #(
         .N_CH(N_CH), .DW(DW), .BURST_LEN(BURST_LEN),
         .TAG_DEPTH(TAG_DEPTH), .PRIO_MODE(g)
      ) dut (
         .sdram_clk    (sdram_clk),
         .sdram_rst_   (sdram_rst_),
         .sd_init_done (sd_init_done),
         .ch_req       (ch_req),
         .ch_we        (ch_we),
         .ch_addr      (ch_addr),
         .ch_wdata     (ch_wdata),
         .ch_valid     (ch_valid[g]),
         .ch_rd_rdy    (ch_rd_rdy[g]),
         .ch_rdata     (ch_rdata[g]),
         .gnt_id       (gnt_id[g]),
         .gnt_busy     (gnt_busy[g]),
         .err_orphan   (err_orphan[g]),
         .sys_addr     (sys_addr[g]),
         .sys_rd       (sys_rd[g]),
         .sys_wr       (sys_wr[g]),
         .sys_wdata    (sys_wdata[g]),
         .sys_rdata    (sys_rdata),
         .sys_rd_rdy   (sys_rd_rdy),
         .sys_burst_rdy(sys_burst_rdy)
      );
   end

   always #5 sdram_clk = ~sdram_clk;

   // Reference model: who holds the port, how many beats it has moved, and the queue of
   // channels still owed a read burst.
   bit m_busy [2];
   bit m_rest [2];
   bit m_lock [2];
   bit m_orphan [2];
   int m_gid [2];
   int m_last [2];
   int m_beats [2];
   int m_ret [2];
   int tagq [2][$];

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      check_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_busy[m]   = 0;
         m_rest[m]   = 0;
         m_lock[m]   = 0;
         m_orphan[m] = 0;
         m_gid[m]    = 0;
         m_last[m]   = N_CH - 1;
         m_beats[m]  = 0;
         m_ret[m]    = 0;
         tagq[m].delete();
      end
   endtask

   function automatic void expect_outputs(input int m, output logic rd, output logic wr,
                                          output logic [31:0] addr, output logic [DW-1:0] wd,
                                          output logic [N_CH-1:0] valid, output logic [N_CH-1:0] rrdy);
      int o;
      o     = m_gid[m];
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wd    = '0;
      valid = '0;
      rrdy  = '0;
      if (m_busy[m]) begin
         wr   = ch_req[o] & ch_we[o];
         rd   = m_lock[m] | (ch_req[o] & ~ch_we[o]);
         addr = ch_addr[32*o +: 32];
         wd   = ch_wdata[DW*o +: DW];
         if ((rd | wr) && sys_burst_rdy) valid[o] = 1'b1;
      end
      if (tagq[m].size() > 0 && sys_rd_rdy) rrdy[tagq[m][0]] = 1'b1;
   endfunction

   task automatic check_dut(input int m);
      logic rd, wr;
      logic [31:0] addr;
      logic [DW-1:0] wd;
      logic [N_CH-1:0] v, rr;
      expect_outputs(m, rd, wr, addr, wd, v, rr);
      check_output($sformatf("dut%0d gnt_busy", m), gnt_busy[m], m_busy[m]);
      check_output($sformatf("dut%0d gnt_id", m), gnt_id[m], m_gid[m]);
      check_output($sformatf("dut%0d sys_rd", m), sys_rd[m], rd);
      check_output($sformatf("dut%0d sys_wr", m), sys_wr[m], wr);
      check_output($sformatf("dut%0d sys_addr", m), sys_addr[m], addr);
      check_output($sformatf("dut%0d sys_wdata", m), sys_wdata[m], wd);
      check_output($sformatf("dut%0d ch_valid", m), ch_valid[m], v);
      check_output($sformatf("dut%0d ch_rd_rdy", m), ch_rd_rdy[m], rr);
      check_output($sformatf("dut%0d ch_rdata", m), ch_rdata[m], sys_rdata);
      check_output($sformatf("dut%0d err_orphan", m), err_orphan[m], m_orphan[m]);
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step(input int m);
      logic rd, wr;
      logic [31:0] addr;
      logic [DW-1:0] wd;
      logic [N_CH-1:0] v, rr;
      int qsz, o, win;
      bit acc;
      expect_outputs(m, rd, wr, addr, wd, v, rr);
      qsz = tagq[m].size();
      o   = m_gid[m];
      acc = m_busy[m] && (rd || wr) && sys_burst_rdy;
      if (sys_rd_rdy) begin
         if (qsz == 0) m_orphan[m] = 1;
         else begin
            m_ret[m]++;
            if (m_ret[m] == BURST_LEN) begin
               void'(tagq[m].pop_front());
               m_ret[m] = 0;
            end
         end
      end
      if (m_busy[m]) begin
         if (acc) begin
            if (rd && !m_lock[m]) begin
               tagq[m].push_back(o);
               m_lock[m] = 1;
            end
            m_beats[m]++;
         end
         if (m_beats[m] == BURST_LEN || (!m_lock[m] && !ch_req[o])) begin
            m_busy[m]  = 0;
            m_rest[m]  = 1;
            m_lock[m]  = 0;
            m_beats[m] = 0;
         end
      end else if (m_rest[m]) begin
         m_rest[m] = 0;
      end else if (sd_init_done) begin
         win = -1;
         for (int k = 0; k < N_CH; k++) begin
            int i;
            i = (m == 0) ? (m_last[m] + 1 + k) % N_CH : k;
            if (win < 0 && ch_req[i] && (ch_we[i] || qsz < TAG_DEPTH)) win = i;
         end
         if (win >= 0) begin
            m_busy[m] = 1;
            m_gid[m]  = win;
            m_last[m] = win;
         end
      end
   endtask

   function automatic bit is_owner(input int i);
      return (m_busy[0] && m_gid[0] == i) || (m_busy[1] && m_gid[1] == i);
   endfunction

   // Percentages: request raise/drop, share of new requests that are reads, sys_rd_rdy,
   // sys_burst_rdy and sd_init_done probabilities.
   task automatic apply_stimulus(input int p_raise, input int p_drop, input int p_read,
                                 input int p_rrdy, input int p_brdy, input int p_init);
      for (int i = 0; i < N_CH; i++) begin
         if (ch_req[i]) begin
            if ($urandom_range(99) < p_drop) ch_req[i] = 1'b0;
         end else if ($urandom_range(99) < p_raise) begin
            if (!is_owner(i)) ch_we[i] = ($urandom_range(99) >= p_read);
            ch_req[i] = 1'b1;
         end
         ch_addr[32*i +: 32]  = $urandom;
         ch_wdata[DW*i +: DW] = DW'($urandom);
      end
      sys_rdata     = DW'($urandom);
      sys_rd_rdy    = ($urandom_range(99) < p_rrdy);
      sys_burst_rdy = ($urandom_range(99) < p_brdy);
      sd_init_done  = ($urandom_range(99) < p_init);
   endtask

   task automatic run_cycles(input int n, input int p_raise, input int p_drop, input int p_read,
                             input int p_rrdy, input int p_brdy, input int p_init);
      repeat (n) begin
         @(negedge sdram_clk);
         apply_stimulus(p_raise, p_drop, p_read, p_rrdy, p_brdy, p_init);
         #1;
         for (int m = 0; m < 2; m++) check_dut(m);
         for (int m = 0; m < 2; m++) model_step(m);
         @(posedge sdram_clk);
      end
   endtask

   task automatic release_reset();
      ch_req        = '0;
      sys_rd_rdy    = 1'b0;
      sys_burst_rdy = 1'b0;
      model_reset();
      @(negedge sdram_clk);
      @(negedge sdram_clk);
      sdram_rst_ = 1'b1;
   endtask

   initial begin
      int waited;
      model_reset();
      release_reset();

      // Everything requesting while the SDRAM is still initialising: nothing may be granted.
      run_cycles(20, 100, 0, 0, 0, 100, 0);
      // All channels streaming writes into an always-ready controller.
      run_cycles(60, 100, 0, 0, 0, 100, 100);
      // Mostly reads with no returned data, so the tag FIFO fills while writes keep flowing.
      run_cycles(120, 60, 5, 80, 0, 90, 100);
      // Drain the FIFO; continued sys_rd_rdy afterwards arrives as orphan data.
      run_cycles(60, 0, 100, 0, 100, 100, 100);
      // Free-running mixed traffic.
      run_cycles(1500, 30, 10, 50, 30, 70, 95);

      // Asynchronous reset in the middle of a write burst.
      waited = 0;
      while (!m_busy[0] && waited < 50) begin
         run_cycles(1, 100, 0, 0, 50, 100, 100);
         waited++;
      end
      check_output("reset_precondition_busy", m_busy[0], 1'b1);
      #2;
      sdram_rst_ = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         check_output($sformatf("dut%0d rst gnt_busy", m), gnt_busy[m], 1'b0);
         check_output($sformatf("dut%0d rst gnt_id", m), gnt_id[m], 0);
         check_output($sformatf("dut%0d rst sys_rd", m), sys_rd[m], 1'b0);
         check_output($sformatf("dut%0d rst sys_wr", m), sys_wr[m], 1'b0);
         check_output($sformatf("dut%0d rst sys_addr", m), sys_addr[m], 0);
         check_output($sformatf("dut%0d rst ch_valid", m), ch_valid[m], 0);
         check_output($sformatf("dut%0d rst ch_rd_rdy", m), ch_rd_rdy[m], 0);
         check_output($sformatf("dut%0d rst err_orphan", m), err_orphan[m], 1'b0);
      end
      release_reset();

      run_cycles(300, 30, 10, 50, 30, 70, 95);

      $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Parametrised N-channel front-end for the SDRAM controller's single host port (sys_* interface of sdram_ctl). It generalises the fixed two-way dwrite/dread mux into a burst-granular arbiter over N_CH channels, with selectable round-robin or fixed priority. A tag FIFO routes returning read data to the channel that issued the read. It sits between the capture/readback engines and sdram_ctl, and runs in the sdram_clk domain.

## Interface
- N_CH, 4: number of channels (2..8)
- DW, 16: data word width
- BURST_LEN, 8: maximum accepted beats per grant (power of two, 2..256)
- TAG_DEPTH, 4: outstanding read bursts tracked (power of two)
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (ch0 highest)

Ports:
- sdram_clk  in  1  clock
- sdram_rst_  in  1  asynchronous active-low reset
- sd_init_done  in  1  SDRAM init complete; no grant is issued while low
- ch_req  in  N_CH  per-channel request
- ch_we  in  N_CH  1 = write, 0 = read; held stable while ch_req is high
- ch_addr  in  N_CH*32  per-channel word address; channel i occupies bits [32i+31:32i]
- ch_wdata  in  N_CH*DW  per-channel write data
- ch_valid  out  N_CH  beat accepted this cycle (address/data consumed)
- ch_rd_rdy  out  N_CH  read data valid for this channel on ch_rdata
- ch_rdata  out  DW  shared read data (= sys_rdata)
- gnt_id  out  clog2(N_CH)  currently granted channel
- gnt_busy  out  1  a grant is active
- err_orphan  out  1  sticky: sys_rd_rdy seen with the tag FIFO empty
- sys_addr  out  32  to controller
- sys_rd, sys_wr  out  1 each  to controller
- sys_wdata  out  DW  to controller
- sys_rdata  in  DW  from controller
- sys_rd_rdy  in  1  read data valid
- sys_burst_rdy  in  1  controller accepts the current beat

## Operation
- FSM states:
  - IDLE: if sd_init_done is high and any channel is eligible, register the winner into gnt_id and go to BURST.
  - BURST: grant is held; each beat is counted.
  - GAP: lasts one cycle, then returns to IDLE. No command is driven during GAP.
- Eligible channel: ch_req is high, and for reads, the tag FIFO is not full.
- Arbitration:
  - PRIO_MODE 0: search starts at (last granted + 1) mod N_CH. After reset the pointer makes ch0 highest priority.
  - PRIO_MODE 1: lowest index wins.
- In BURST, with g = gnt_id:
  - sys_addr = ch_addr[g], sys_wdata = ch_wdata[g].
  - sys_wr = ch_req[g] & ch_we[g].
  - sys_rd = rd_lock | (ch_req[g] & ~ch_we[g]).
  - Outside BURST, sys_rd and sys_wr are 0 and sys_addr and sys_wdata are 0.
- A beat is accepted when (sys_rd | sys_wr) & sys_burst_rdy is high. On acceptance, ch_valid[g] pulses and the beat counter bcnt increments.
- Write burst ends (go to GAP):
  - bcnt reaches BURST_LEN, or
  - ch_req[g] is low in BURST. A truncated write is legal.
- Read burst:
  - The first accepted beat sets rd_lock and pushes g into the tag FIFO.
  - While rd_lock is set, sys_rd stays high regardless of ch_req until BURST_LEN beats are accepted. Reads are always full bursts.
  - The burst then ends and rd_lock clears.
- Return path:
  - While the FIFO is non-empty, ch_rd_rdy[head] = sys_rd_rdy.
  - rcnt counts returned beats. On the BURST_LEN-th beat the FIFO pops and rcnt clears.
- Orphan data: sys_rd_rdy with the FIFO empty is dropped (no ch_rd_rdy) and sets err_orphan. err_orphan clears only on reset.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Reset (asynchronous, any state):
  - State returns to IDLE; bcnt, rcnt, rd_lock, FIFO pointers and err_orphan clear.
  - gnt_id = 0, gnt_busy = 0, all outputs 0, RR pointer = N_CH-1 (so ch0 is searched first).
  - Mid-burst reset aborts with no further pushes or pops.

## Timing
- Grant latency: ch_req rising in IDLE gives BURST (gnt_busy = 1) on the next edge. The first beat can be accepted in that BURST cycle.
- Throughput: one beat per cycle while sys_burst_rdy is high. There are 2 dead cycles (GAP + IDLE) between grants.
- ch_valid, sys_rd, sys_wr and ch_rd_rdy are combinational from registered state and current inputs. ch_rdata passes sys_rdata through with 0-cycle latency.
- bcnt and rcnt are clog2(BURST_LEN)+1 bits wide; the tag FIFO holds TAG_DEPTH entries of clog2(N_CH) bits.
- sd_init_done falling mid-burst does not abort; it only blocks new grants.

## Test plan
- Reset and init gating:
  - Stimulus: all ch_req high, sd_init_done low for 20 cycles.
  - Required: gnt_busy = 0, sys_rd = sys_wr = 0, all outputs 0. One cycle after sd_init_done rises, gnt_id = 0.
- Round-robin fairness:
  - Stimulus: N_CH = 4, PRIO_MODE 0, all channels request writes continuously, sys_burst_rdy = 1.
  - Required: grant order 0,1,2,3,0; each grant gives exactly 8 ch_valid pulses; 2 idle cycles between grants.
- Fixed priority:
  - Stimulus: PRIO_MODE 1, ch1 and ch3 request continuously.
  - Required: ch3 is never granted while ch1 requests.
- Truncated write vs locked read:
  - Stimulus 1: ch2 write drops ch_req after 3 beats.
    Required: burst ends at 3 beats.
  - Stimulus 2: ch0 read drops ch_req after 2 beats.
    Required: sys_rd stays high until 8 beats are accepted; one tag is pushed.
- Read routing with full FIFO:
  - Stimulus: TAG_DEPTH = 4 read bursts from ch1,ch2,ch1,ch3; sys_rd_rdy held off.
  - Required: a 5th read request is not granted, while a concurrent write is still granted. After 32 sys_rd_rdy beats, ch_rd_rdy routes 8 beats each to ch1, ch2, ch1, ch3 in order.
- Orphan data and async reset:
  - Stimulus 1: sys_rd_rdy pulses with the FIFO empty.
    Required: err_orphan = 1 and no ch_rd_rdy.
  - Stimulus 2: assert sdram_rst_ low mid-burst between clock edges.
    Required: outputs go to 0 immediately and err_orphan clears.
